// File: rtl/int_div_seq.sv
// Iterative restoring divider (RV64M DIV/DIVU/REM/REMU and W forms), radix-2 or radix-4 with INT_DIV_RADIX4_EN.
// Latency: start at edge k -> o_valid in cycle k+N+2 (N = quotient steps), divide-by-zero/overflow k+2.
// Backpressure: none; o_busy high while in flight and i_ena is ignored then, not queued.
module int_div_seq #(
  parameter int RISCV_ARCH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ena,
  input  logic                  i_unsigned,
  input  logic                  i_residual,
  input  logic                  i_rv32,
  input  logic [RISCV_ARCH-1:0] i_a1,
  input  logic [RISCV_ARCH-1:0] i_a2,
  output logic [RISCV_ARCH-1:0] o_res,
  output logic                  o_valid,
  output logic                  o_busy
);

  localparam int W  = RISCV_ARCH;
  localparam int CW = $clog2(W) + 1;
`ifdef INT_DIV_RADIX4_EN
  localparam logic [CW-1:0] CNT_FULL = CW'(W / 2);
  localparam logic [CW-1:0] CNT_HALF = CW'(16);
`else
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_HALF = CW'(32);
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    rem, quot, dvsr;
  logic            residual, rv32, neg_q, neg_r, special;

  logic [W-1:0]    a1_ext, a2_ext, a1_abs, a2_abs;
  logic            a1_neg, a2_neg, div_zero, ovf;
  logic [2*W-1:0]  step_res;
  logic [W-1:0]    q_fix, r_fix, sel;
  logic [W-1:0]    res_nxt;

  // One restoring step: shift {rem,quot} left, keep rem-divisor when non-negative.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r, input logic [W-1:0] q,
                                              input logic [W-1:0] d);
    logic [W:0] sh;
    logic [W:0] diff;
    sh   = {r, q[W-1]};
    diff = sh - {1'b0, d};
    if (!diff[W])
      div_step = {diff[W-1:0], q[W-2:0], 1'b1};
    else
      div_step = {sh[W-1:0], q[W-2:0], 1'b0};
  endfunction

  always_comb begin
    a1_ext = i_a1;
    a2_ext = i_a2;
    if (i_rv32) begin
      a1_ext = {{(W-32){~i_unsigned & i_a1[31]}}, i_a1[31:0]};
      a2_ext = {{(W-32){~i_unsigned & i_a2[31]}}, i_a2[31:0]};
    end
    a1_neg   = ~i_unsigned & a1_ext[W-1];
    a2_neg   = ~i_unsigned & a2_ext[W-1];
    a1_abs   = a1_neg ? -a1_ext : a1_ext;
    a2_abs   = a2_neg ? -a2_ext : a2_ext;
    div_zero = (a2_ext == '0);
    ovf      = ~i_unsigned & (a1_ext == {1'b1, {(W-1){1'b0}}} | (i_rv32 & a1_ext == {{(W-31){1'b1}}, 31'b0}))
               & (&a2_ext);
  end

  always_comb begin
    step_res = div_step(rem, quot, dvsr);
`ifdef INT_DIV_RADIX4_EN
    step_res = div_step(step_res[2*W-1:W], step_res[W-1:0], dvsr);
`endif
  end

  // Special cases already hold their final raw value; only sign/W fixup for normal ops.
  always_comb begin
    q_fix = (neg_q & ~special) ? -quot : quot;
    r_fix = (neg_r & ~special) ? -rem  : rem;
    sel   = residual ? r_fix : q_fix;
    res_nxt = rv32 ? {{(W-32){sel[31]}}, sel[31:0]} : sel;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_ena) state_nxt = (div_zero | ovf) ? FIX : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      residual <= 1'b0;
      rv32     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      special  <= 1'b0;
      o_res    <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: if (i_ena) begin
          residual <= i_residual;
          rv32     <= i_rv32;
          neg_q    <= a1_neg ^ a2_neg;
          neg_r    <= a1_neg;
          dvsr     <= a2_abs;
          if (div_zero) begin
            special <= 1'b1;
            quot    <= '1;
            rem     <= a1_ext;
          end else if (ovf) begin
            special <= 1'b1;
            quot    <= a1_ext;
            rem     <= '0;
          end else begin
            special <= 1'b0;
            rem     <= '0;
            // W magnitudes fit in 32 bits; park them at the top so only 32 steps are needed.
            quot    <= i_rv32 ? {a1_abs[31:0], {(W-32){1'b0}}} : a1_abs;
            cnt     <= i_rv32 ? CNT_HALF : CNT_FULL;
          end
        end
        CALC: begin
          {rem, quot} <= step_res;
          cnt         <= cnt - CW'(1);
        end
        FIX: begin
          o_res   <= res_nxt;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_int_div_seq.sv
// Directed self-checking bench for int_div_seq (both radix builds).
module tb_int_div_seq;

`ifdef INT_DIV_RADIX4_EN
  localparam int NF = 32;
  localparam int NH = 16;
`else
  localparam int NF = 64;
  localparam int NH = 32;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_ena, i_unsigned, i_residual, i_rv32;
  logic [63:0] i_a1, i_a2, o_res;
  logic        o_valid, o_busy;
  int          checks = 0;
  int          errors = 0;

  int_div_seq #(.RISCV_ARCH(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ena(i_ena), .i_unsigned(i_unsigned),
    .i_residual(i_residual), .i_rv32(i_rv32), .i_a1(i_a1), .i_a2(i_a2),
    .o_res(o_res), .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edges counted after the start edge k; o_valid registered at edge k+N+1 is cycle k+N+2.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!o_valid && lat < 200) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic start_op(input logic uns, input logic res, input logic rv32,
                          input logic [63:0] a1, input logic [63:0] a2);
    i_ena = 1'b1; i_unsigned = uns; i_residual = res; i_rv32 = rv32;
    i_a1 = a1; i_a2 = a2;
    @(posedge i_clk); #1;
    i_ena = 1'b0;
    i_a1 = {$urandom, $urandom};
    i_a2 = {$urandom, $urandom};
    i_unsigned = $urandom_range(0, 1);
    i_residual = $urandom_range(0, 1);
    i_rv32 = $urandom_range(0, 1);
  endtask

  task automatic run_op(input string tag, input logic uns, input logic res, input logic rv32,
                        input logic [63:0] a1, input logic [63:0] a2,
                        input logic [63:0] exp, input int lat_exp);
    int lat;
    start_op(uns, res, rv32, a1, a2);
    wait_valid(0, lat);
    chk64({tag, " res"}, o_res, exp);
    chki({tag, " lat"}, lat, lat_exp);
  endtask

  initial begin
    int lat;
    int nvalid;
    i_rst = 1'b1; i_ena = 1'b0; i_unsigned = 1'b0; i_residual = 1'b0; i_rv32 = 1'b0;
    i_a1 = '0; i_a2 = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk64("rst res", o_res, 64'h0);
    chki("rst valid", int'(o_valid), 0);
    chki("rst busy", int'(o_busy), 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    run_op("div 100/7", 0, 0, 0, 64'd100, 64'd7, 64'd14, NF + 1);
    @(posedge i_clk); #1;
    chki("valid width", int'(o_valid), 0);
    chk64("res held", o_res, 64'd14);

    run_op("rem -100/7", 0, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, NF + 1);
    run_op("div -100/7", 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, NF + 1);
    run_op("div 100/-7", 0, 0, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, NF + 1);
    run_op("rem 100/-7", 0, 1, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, NF + 1);

    run_op("divu 5/0", 1, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu 5/0", 1, 1, 0, 64'd5, 64'd0, 64'd5, 1);
    run_op("rem -100/0", 0, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 64'hFFFF_FFFF_FFFF_FF9C, 1);
    run_op("div ovf", 0, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("rem ovf", 0, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);

    run_op("divw ovf", 0, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw ovf", 0, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1);
    run_op("divw -100/7", 0, 0, 1, 64'h1234_5678_FFFF_FF9C, 64'hABCD_0000_0000_0007,
           64'hFFFF_FFFF_FFFF_FFF2, NH + 1);
    run_op("divuw", 1, 0, 1, 64'h1234_5678_FFFF_FF9C, 64'h0000_0001_0000_0007,
           64'h0000_0000_2492_4916, NH + 1);
    run_op("remuw", 1, 1, 1, 64'h1234_5678_FFFF_FF9C, 64'h0000_0001_0000_0007, 64'd2, NH + 1);
    run_op("remuw /0", 1, 1, 1, 64'h0000_0000_8000_0005, 64'h5555_0000_0000_0000,
           64'hFFFF_FFFF_8000_0005, 1);
    run_op("divu max/2", 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, NF + 1);
    run_op("remu max/2", 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, NF + 1);

    // Second start while busy must be dropped; the next start lands in the o_valid cycle.
    start_op(0, 0, 0, 64'd100, 64'd7);
    chki("busy after start", int'(o_busy), 1);
    repeat (9) @(posedge i_clk);
    #1;
    i_ena = 1'b1; i_unsigned = 1'b1; i_residual = 1'b1; i_a1 = 64'd1000; i_a2 = 64'd3;
    @(posedge i_clk); #1;
    i_ena = 1'b0;
    wait_valid(10, lat);
    chk64("ignored ena res", o_res, 64'd14);
    chki("ignored ena lat", lat, NF + 1);
    run_op("b2b remu", 1, 1, 0, 64'd1000, 64'd3, 64'd1, NF + 1);

    start_op(0, 0, 0, 64'd100, 64'd7);
    repeat (19) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chki("abort busy", int'(o_busy), 0);
    chk64("abort res", o_res, 64'd0);
    nvalid = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_valid) nvalid++;
      @(posedge i_clk); #1;
    end
    chki("abort no valid", nvalid, 0);
    run_op("after rst divu", 1, 0, 0, 64'd1000, 64'd3, 64'd333, NF + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
